// File: rtl/dispatcher_pkg.sv
// Shared definitions for the block dispatcher and its round-robin helper.
// Contents:
//   state_e            - dispatcher FSM state encoding
//   Default*           - default parameter values (CU count, index/mu widths)
//   ptr_width()        - width of a CU index/pointer for a given CU count
package dispatcher_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPick  = 3'd1,
        StIssue = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam int unsigned DefaultNCu        = 4;
    localparam int unsigned DefaultIndexWidth = 8;
    localparam int unsigned DefaultMaxMuLog   = 8;

    // A single CU still needs a 1-bit pointer so the vectors stay legal.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin first-free finder.
// Ports:
//   free_i  - one bit per requester, 1 = available
//   ptr_i   - index where the search starts (wraps modulo N)
//   grant_o - one-hot selection of the first free entry at or after ptr_i
//   valid_o - 1 when any entry is free
module rr_select
    import dispatcher_pkg::*;
#(
    parameter int unsigned N    = DefaultNCu,
    parameter int unsigned PtrW = ptr_width(N)
) (
    input  logic [N-1:0]    free_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic            valid_o
);

    logic [PtrW-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr_i) + k) % N);
            if (!valid_o && free_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Top-level block scheduler of the matrix-multiply coprocessor. Walks every output
// block C_ij in row-major order and hands each to a free control unit (CU).
// Ports:
//   i_Clock, i_Reset      - clock, asynchronous active-high reset
//   i_Start, i_mu         - start request and blocks-per-side (latched on start)
//   o_Row_Index           - per-CU row index, slice c belongs to CU c
//   o_Column_Index        - per-CU column index
//   o_Indexes_Ready       - per-CU request, at most one bit high
//   i_Indexes_Received    - per-CU acknowledge (level)
//   i_Result_Ready        - per-CU result-written flag (level)
//   o_Busy, o_Done        - run status
//   o_Blocks_Completed    - blocks whose results are back for the current run
module block_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int unsigned N_CU        = DefaultNCu,
    parameter int unsigned INDEX_WIDTH = DefaultIndexWidth,
    parameter int unsigned MAX_MU_LOG  = DefaultMaxMuLog
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Start,
    input  logic [MAX_MU_LOG-1:0]       i_mu,
    output logic [N_CU*INDEX_WIDTH-1:0] o_Row_Index,
    output logic [N_CU*INDEX_WIDTH-1:0] o_Column_Index,
    output logic [N_CU-1:0]             o_Indexes_Ready,
    input  logic [N_CU-1:0]             i_Indexes_Received,
    input  logic [N_CU-1:0]             i_Result_Ready,
    output logic                        o_Busy,
    output logic                        o_Done,
    output logic [2*MAX_MU_LOG-1:0]     o_Blocks_Completed
);

    localparam int unsigned PtrW = ptr_width(N_CU);
    localparam int unsigned CntW = 2 * MAX_MU_LOG;
    localparam logic [MAX_MU_LOG-1:0] MuOne = MAX_MU_LOG'(1);

    state_e                      state_q;
    logic [MAX_MU_LOG-1:0]       mu_q, i_q, j_q;
    logic [N_CU-1:0]             busy_q, busy_d, ready_q;
    logic [PtrW-1:0]             ptr_q, sel_q, grant_idx;
    logic [N_CU*INDEX_WIDTH-1:0] row_q, col_q;
    logic [CntW-1:0]             count_q, count_inc, mu_sq;
    logic                        run_q, done_q;

    logic [N_CU-1:0] free, grant, complete_m, accept_m;
    logic            grant_valid, accept, last_block;

    assign free = ~busy_q;

    rr_select #(
        .N    (N_CU),
        .PtrW (PtrW)
    ) u_rr_select (
        .free_i  (free),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        // A CU with a pending request still shows its old result flag; that is not a completion.
        complete_m = busy_q & i_Result_Ready & ~ready_q;
        // Result flag still high means the ack is left over from the previous job.
        accept_m   = (state_q == StIssue) ? (ready_q & i_Indexes_Received & ~i_Result_Ready)
                                          : '0;
        accept     = |accept_m;
        busy_d     = (busy_q & ~complete_m) | accept_m;
        count_inc  = '0;
        grant_idx  = '0;
        for (int unsigned c = 0; c < N_CU; c++) begin
            count_inc = count_inc + CntW'(complete_m[c]);
            if (grant[c]) grant_idx = PtrW'(c);
        end
        mu_sq      = CntW'(mu_q) * CntW'(mu_q);
        last_block = (i_q == mu_q - MuOne) && (j_q == mu_q - MuOne);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= StIdle;
            mu_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= '0;
            ready_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_q + count_inc;
            unique case (state_q)
                StIdle, StDone: begin
                    if (i_Start) begin
                        mu_q    <= i_mu;
                        i_q     <= '0;
                        j_q     <= '0;
                        count_q <= '0;
                        if (i_mu == '0) begin
                            state_q <= StDone;
                            run_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StPick;
                            run_q   <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                StPick: begin
                    if (grant_valid) begin
                        sel_q   <= grant_idx;
                        ready_q <= grant;
                        row_q[32'(grant_idx)*INDEX_WIDTH +: INDEX_WIDTH] <= INDEX_WIDTH'(i_q);
                        col_q[32'(grant_idx)*INDEX_WIDTH +: INDEX_WIDTH] <= INDEX_WIDTH'(j_q);
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (accept) begin
                        ready_q <= '0;
                        ptr_q   <= (sel_q == PtrW'(N_CU - 1)) ? '0 : sel_q + PtrW'(1);
                        if (last_block) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StPick;
                            if (j_q == mu_q - MuOne) begin
                                j_q <= '0;
                                i_q <= i_q + MuOne;
                            end else begin
                                j_q <= j_q + MuOne;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (busy_q == '0 && count_q == mu_sq) begin
                        state_q <= StDone;
                        run_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_Row_Index        = row_q;
    assign o_Column_Index     = col_q;
    assign o_Indexes_Ready    = ready_q;
    assign o_Busy             = run_q;
    assign o_Done             = done_q;
    assign o_Blocks_Completed = count_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Scoreboard bench for block_dispatcher: each run pushes its expected (cu, i, j)
// dispatch sequence; a monitor pops one entry per new request. A behavioural
// CU model answers requests with configurable ack delay, work time and hold.
module tb_block_dispatcher;

    localparam int unsigned NCu = 4;
    localparam int unsigned Iw  = 8;
    localparam int unsigned Mw  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [Mw-1:0]     mu;
    logic [NCu*Iw-1:0] row, col;
    logic [NCu-1:0]    rdy, recv, res;
    logic              busy, done;
    logic [2*Mw-1:0]   blocks;

    always #5 clk = ~clk;

    block_dispatcher #(
        .N_CU        (NCu),
        .INDEX_WIDTH (Iw),
        .MAX_MU_LOG  (Mw)
    ) dut (
        .i_Clock            (clk),
        .i_Reset            (rst),
        .i_Start            (start),
        .i_mu               (mu),
        .o_Row_Index        (row),
        .o_Column_Index     (col),
        .o_Indexes_Ready    (rdy),
        .i_Indexes_Received (recv),
        .i_Result_Ready     (res),
        .o_Busy             (busy),
        .o_Done             (done),
        .o_Blocks_Completed (blocks)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: cu = -1 means any CU is acceptable.
    typedef struct { int cu; int i; int j; } exp_t;
    exp_t exp_q[$];
    int   issued = 0;
    int   stale_seen = 0;

    task automatic push_run(input int m, input bit fixed_cu);
        exp_t e;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < m; j++) begin
                e.cu = fixed_cu ? ((i * m + j) % NCu) : -1;
                e.i  = i;
                e.j  = j;
                exp_q.push_back(e);
            end
        end
    endtask

    // CU model configuration
    int             ack_delay = 0;
    int             work_cycles = 10;
    bit             sticky = 0;
    bit             hold = 0;
    bit             mute = 0;
    logic [NCu-1:0] release_m = '0;
    int             mode_a[NCu];
    int             dly_a[NCu];
    int             wcnt_a[NCu];

    // CU model: 0 idle/waiting for request, 1 acked waiting for request drop, 2 working.
    initial begin
        recv = '0;
        res  = '0;
        for (int c = 0; c < NCu; c++) begin
            mode_a[c] = 0; dly_a[c] = 0; wcnt_a[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                recv = '0;
                res  = '0;
                for (int c = 0; c < NCu; c++) begin
                    mode_a[c] = 0; dly_a[c] = 0; wcnt_a[c] = 0;
                end
            end else begin
                for (int c = 0; c < NCu; c++) begin
                    case (mode_a[c])
                        0: if (rdy[c] && !mute) begin
                            if (dly_a[c] >= ack_delay) begin
                                recv[c]   = 1'b1;
                                res[c]    = 1'b0;
                                wcnt_a[c] = work_cycles;
                                dly_a[c]  = 0;
                                mode_a[c] = 1;
                            end else begin
                                dly_a[c]++;
                            end
                        end
                        1: if (!rdy[c]) begin
                            if (!sticky) recv[c] = 1'b0;
                            mode_a[c] = 2;
                        end
                        default: begin
                            if (hold) begin
                                if (release_m[c]) begin
                                    res[c] = 1'b1; mode_a[c] = 0;
                                end
                            end else if (wcnt_a[c] <= 0) begin
                                res[c] = 1'b1; mode_a[c] = 0;
                            end else begin
                                wcnt_a[c]--;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Monitor: compares every new request against the scoreboard and checks that a
    // stale ack (received and result both high) is never accepted.
    initial begin
        logic [NCu-1:0] prev_rdy;
        bit             stale_prev;
        int             stale_cu;
        int             cf;
        exp_t           e;
        prev_rdy   = '0;
        stale_prev = 0;
        stale_cu   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_rdy   = '0;
                stale_prev = 0;
            end else begin
                if (stale_prev) check("stale_ack_masked", 64'(rdy[stale_cu]), 64'd1);
                stale_prev = 0;
                if (rdy != '0 && prev_rdy == '0) begin
                    check("req_onehot", 64'($countones(rdy)), 64'd1);
                    cf = 0;
                    for (int c = 0; c < NCu; c++) if (rdy[c]) cf = c;
                    issued++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: cu %0d got (%0d,%0d), expected no request",
                                 cf, row[cf*Iw +: Iw], col[cf*Iw +: Iw]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cu >= 0) check("req_cu", 64'(cf), 64'(e.cu));
                        check("req_row", 64'(row[cf*Iw +: Iw]), 64'(e.i));
                        check("req_col", 64'(col[cf*Iw +: Iw]), 64'(e.j));
                    end
                end
                for (int c = 0; c < NCu; c++) begin
                    if (rdy[c] && recv[c] && res[c]) begin
                        stale_prev = 1;
                        stale_cu   = c;
                        stale_seen++;
                    end
                end
                prev_rdy = rdy;
            end
        end
    end

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk); #2;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: o_Done=%b after %0d cycles, expected 1", name, done, limit);
        end
    endtask

    task automatic wait_issued(input string name, input int target, input int limit);
        int n;
        n = 0;
        while (issued < target && n < limit) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, 64'(issued), 64'(target));
    endtask

    task automatic pulse_start(input int m);
        @(negedge clk); #2;
        start = 1'b1;
        mu    = Mw'(m);
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;
        rst   = 1'b1;
        start = 1'b0;
        mu    = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_row", 64'(row), 64'd0);
        check("rst_col", 64'(col), 64'd0);
        check("rst_ready", 64'(rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_blocks", 64'(blocks), 64'd0);
        rst = 1'b0;

        // mu=2, fast CUs: CUs 0..3 receive the four blocks in order.
        ack_delay = 0; work_cycles = 10;
        issued = 0;
        push_run(2, 1'b1);
        @(negedge clk); #2;
        start = 1'b1;
        mu    = Mw'(2);
        @(negedge clk); #2;
        start = 1'b0;
        check("t1_pick_no_req", 64'(rdy), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_done_low", 64'(done), 64'd0);
        @(negedge clk); #2;
        check("t1_first_req", 64'(rdy), 64'd1);
        wait_done("t1_done", 200);
        check("t1_blocks", 64'(blocks), 64'd4);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // mu=3, slow CUs: PICK must stall once all four are busy.
        work_cycles = 20;
        issued = 0;
        push_run(3, 1'b0);
        pulse_start(3);
        wait_issued("t2_first_four", 4, 100);
        repeat (2) @(negedge clk);
        stalled = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #2;
            if (rdy != '0) stalled = 0;
        end
        check("t2_stall", 64'(stalled), 64'd1);
        wait_done("t2_done", 400);
        check("t2_blocks", 64'(blocks), 64'd9);
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Two CUs finish in the same cycle: count steps by two and both take new blocks.
        hold = 1; work_cycles = 5;
        issued = 0;
        push_run(3, 1'b0);
        pulse_start(3);
        wait_issued("t3_first_four", 4, 100);
        repeat (3) @(negedge clk);
        #2;
        check("t3_blocks_held", 64'(blocks), 64'd0);
        check("t3_stalled", 64'(rdy), 64'd0);
        release_m = 4'b0011;
        @(negedge clk); #2;
        release_m = '0;
        @(negedge clk); #2;
        check("t3_dual_complete", 64'(blocks), 64'd2);
        wait_issued("t3_both_free", 6, 30);
        hold = 0;
        wait_done("t3_done", 400);
        check("t3_blocks", 64'(blocks), 64'd9);
        check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Sticky acks: re-requested CUs show a stale ack until the result flag drops.
        sticky = 1; ack_delay = 2; work_cycles = 3;
        stale_seen = 0;
        push_run(3, 1'b0);
        pulse_start(3);
        wait_done("t4_done", 400);
        check("t4_stale_seen", 64'(stale_seen > 0), 64'd1);
        check("t4_blocks", 64'(blocks), 64'd9);
        check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
        sticky = 0; ack_delay = 0;

        // Reset while a request is pending with mu=4.
        mute = 1;
        issued = 0;
        begin
            exp_t e;
            e.cu = -1; e.i = 0; e.j = 0;
            exp_q.push_back(e);
        end
        pulse_start(4);
        wait_issued("t5_req_up", 1, 20);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 64'(rdy), 64'd0);
        check("t5_rst_row", 64'(row), 64'd0);
        check("t5_rst_col", 64'(col), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_blocks", 64'(blocks), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst  = 1'b0;
        mute = 0;

        // mu=1 after reset, with a second start (mu=5) that must be ignored.
        work_cycles = 4;
        push_run(1, 1'b1);
        @(negedge clk); #2;
        start = 1'b1;
        mu    = Mw'(1);
        @(negedge clk); #2;
        mu    = Mw'(5);
        @(negedge clk); #2;
        start = 1'b0;
        wait_done("t6_done", 100);
        repeat (5) @(negedge clk);
        #2;
        check("t6_blocks", 64'(blocks), 64'd1);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

        // mu=0: done two edges later, no request ever raised.
        pulse_start(0);
        @(negedge clk); #2;
        check("t7_done", 64'(done), 64'd1);
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_blocks", 64'(blocks), 64'd0);
        repeat (4) @(negedge clk);
        #2;
        check("t7_no_req", 64'(rdy), 64'd0);
        check("t7_done_hold", 64'(done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
